// File: rtl/ttt_game_ctrl_if.sv
// Move handshake between the move source and the tic-tac-toe controller.
// Latency: n/a (wires only); ack/err return one cycle after the accepting edge.
// Backpressure: source holds move_valid/move_cell until move_ready is seen high at an edge.
interface ttt_game_ctrl_if;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_ready;
    logic       move_ack;
    logic       move_err;

    modport master (
        output move_valid,
        output move_cell,
        input  move_ready,
        input  move_ack,
        input  move_err
    );

    modport slave (
        input  move_valid,
        input  move_cell,
        output move_ready,
        output move_ack,
        output move_err
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: owns the board, alternates X/O moves, detects win/draw.
// Latency: ack/err one cycle after the accepting edge; result (turn or game_over) one cycle later.
// Backpressure: move_ready low during CHECK, DONE and while new_game is asserted.

// Detects three-in-a-row on a single player's 9-bit mark map.
module win_detect (
    input  logic [8:0] board,
    output logic       win
);
    // Eight possible lines: three rows, three columns, two diagonals.
    always_comb begin
        win = (board[0] & board[1] & board[2]) |
              (board[3] & board[4] & board[5]) |
              (board[6] & board[7] & board[8]) |
              (board[0] & board[3] & board[6]) |
              (board[1] & board[4] & board[7]) |
              (board[2] & board[5] & board[8]) |
              (board[0] & board[4] & board[8]) |
              (board[2] & board[4] & board[6]);
    end
endmodule

module ttt_game_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  new_game,
    ttt_game_ctrl_if.slave        move,
    output logic                  turn,
    output logic [8:0]            x_board,
    output logic [8:0]            o_board,
    output logic [3:0]            move_count,
    output logic                  game_over,
    output logic [1:0]            winner
);
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       turn_nxt;
    logic [8:0] x_board_nxt;
    logic [8:0] o_board_nxt;
    logic [3:0] move_count_nxt;
    logic [1:0] winner_nxt;
    logic       move_ack_q;
    logic       move_err_q;
    logic       move_ack_nxt;
    logic       move_err_nxt;

    logic       x_win;
    logic       o_win;
    logic       mover_win;
    logic [8:0] cell_bit;
    logic       legal;

    win_detect u_win_x (.board(x_board), .win(x_win));
    win_detect u_win_o (.board(o_board), .win(o_win));

    // Only the player who just moved can have completed a line.
    assign mover_win = turn ? o_win : x_win;

    // Out-of-range cells decode to no bit so they can never look free.
    always_comb begin
        cell_bit = 9'd0;
        if (move.move_cell <= 4'd8) begin
            cell_bit = 9'd1 << move.move_cell;
        end
    end

    assign legal           = (cell_bit != 9'd0) && ((cell_bit & (x_board | o_board)) == 9'd0);
    assign move.move_ready = (state == PLAY) && !new_game;
    assign move.move_ack   = move_ack_q;
    assign move.move_err   = move_err_q;
    assign game_over       = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath decode; new_game overrides everything.
    always_comb begin
        state_nxt      = state;
        turn_nxt       = turn;
        x_board_nxt    = x_board;
        o_board_nxt    = o_board;
        move_count_nxt = move_count;
        winner_nxt     = winner;
        move_ack_nxt   = 1'b0;
        move_err_nxt   = 1'b0;
        if (new_game) begin
            state_nxt      = PLAY;
            turn_nxt       = 1'b0;
            x_board_nxt    = 9'd0;
            o_board_nxt    = 9'd0;
            move_count_nxt = 4'd0;
            winner_nxt     = 2'b00;
        end else begin
            case (state)
                PLAY: begin
                    if (move.move_valid) begin
                        if (legal) begin
                            if (turn) begin
                                o_board_nxt = o_board | cell_bit;
                            end else begin
                                x_board_nxt = x_board | cell_bit;
                            end
                            move_count_nxt = move_count + 4'd1;
                            move_ack_nxt   = 1'b1;
                            state_nxt      = CHECK;
                        end else begin
                            move_err_nxt = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Win is checked before draw so a 9th-move win is reported as a win.
                    if (mover_win) begin
                        winner_nxt = turn ? 2'b10 : 2'b01;
                        state_nxt  = DONE;
                    end else if (move_count == 4'd9) begin
                        winner_nxt = 2'b11;
                        state_nxt  = DONE;
                    end else begin
                        turn_nxt  = ~turn;
                        state_nxt = PLAY;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = PLAY;
                end
            endcase
        end
    end

    // Board, turn, result and handshake pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turn       <= 1'b0;
            x_board    <= 9'd0;
            o_board    <= 9'd0;
            move_count <= 4'd0;
            winner     <= 2'b00;
            move_ack_q <= 1'b0;
            move_err_q <= 1'b0;
        end else begin
            turn       <= turn_nxt;
            x_board    <= x_board_nxt;
            o_board    <= o_board_nxt;
            move_count <= move_count_nxt;
            winner     <= winner_nxt;
            move_ack_q <= move_ack_nxt;
            move_err_q <= move_err_nxt;
        end
    end
endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Sequential game controller for two-player tic-tac-toe. It owns the 3x3 board state, accepts one move per turn from an external move source, and alternates turns X then O. It rejects illegal moves and checks the mover's marks for a win by instantiating two `win_detect` blocks, one per player. It reports win, draw, or game-in-progress to the display/top-level logic.

## Interface
Parameters: none (board size fixed at 9 cells).

Cell indexing: cells 0..8 map to board positions A..I, row-major (0=A top-left, 4=E centre, 8=I bottom-right).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `new_game`  in  1  synchronous restart request, level-sampled
- `move_valid`  in  1  move request present
- `move_cell`  in  4  target cell 0..8; values 9..15 are illegal
- `move_ready`  out  1  controller can accept a move this cycle
- `move_ack`  out  1  one-cycle pulse: move accepted and placed
- `move_err`  out  1  one-cycle pulse: move rejected
- `turn`  out  1  player to move: 0=X, 1=O
- `x_board`  out  9  X marks, bit n = cell n
- `o_board`  out  9  O marks, bit n = cell n
- `move_count`  out  4  accepted moves this game, 0..9
- `game_over`  out  1  high in DONE state
- `winner`  out  2  00=none, 01=X, 10=O, 11=draw

## Operation
- States: PLAY, CHECK, DONE.
- Reset (`reset_n`=0, immediate):
  - state=PLAY
  - boards=0, `move_count`=0, `turn`=0
  - `winner`=00, `game_over`=0
  - `move_ack`=0, `move_err`=0
  - `move_ready`=1 once reset deasserts
- `move_ready` = (state==PLAY) and not `new_game`.
- PLAY, handshake (`move_valid` and `move_ready` at a rising edge):
  - Legal = `move_cell` ≤ 8 and the cell bit is clear in both boards.
  - Legal move: set the bit in the current player's board, increment `move_count`, pulse `move_ack`, go to CHECK.
  - Illegal move: boards, `turn` and `move_count` unchanged; pulse `move_err`; stay in PLAY.
- CHECK, one cycle. Evaluate `win_detect` on the board of the player who just moved:
  - Win: `winner` = 01 (X) or 10 (O); go to DONE; `turn` unchanged.
  - Else if `move_count`==9: `winner`=11; go to DONE.
  - Else: toggle `turn`; go to PLAY.
- DONE:
  - `game_over`=1; boards and `winner` hold.
  - `move_valid` is ignored: no ack, no err.
- `new_game`=1 at a rising edge:
  - Valid in any state and takes priority over a simultaneous move.
  - Next state: PLAY with boards, count, `turn` and `winner` cleared.
  - No `move_ack`/`move_err` pulse.
- A win on the 9th move reports the winner, not a draw (the win check precedes the draw check).
- Only the mover's board is checked; the opponent's board cannot change during that turn.

## Timing
- Edge 0: move sampled.
- Cycle 1 (after edge 0):
  - Board bit and `move_count` updated; `move_ack` high; state CHECK; `move_ready`=0.
- Cycle 2 (after edge 1), one of:
  - `turn` toggled and `move_ready`=1.
  - `game_over`=1 with final `winner`.
- Accepted-move throughput: one move per 2 cycles.
- Illegal move:
  - `move_err` high in cycle 1; `move_ready` stays high.
  - A corrected move can be sampled at edge 1.
- `move_ack`/`move_err` are registered and last exactly one cycle.
- `x_board`, `o_board`, `winner`, `game_over` and `turn` are registered outputs.
- Async reset mid-CHECK: all outputs return to reset values immediately; the pending move is discarded.

## Test plan
- Reset, then X plays cell 4:
  - `move_ack` in cycle 1; `x_board`=9'h010; `move_count`=1.
  - Cycle 2: `turn`=1, `move_ready`=1.
- X to cell 4, then O to cell 4:
  - `move_err` pulse; `o_board`=0; `turn` stays 1; `move_count`=1.
- Invalid index: `move_cell`=9 → `move_err`; no state change.
- X row win, moves X0, O3, X1, O4, X2:
  - Two cycles after the last move: `game_over`=1, `winner`=01, `x_board`=9'h007.
  - A further `move_valid` is ignored.
- Draw, moves X0, O1, X2, O4, X3, O5, X7, O6, X8:
  - `move_count`=9, `winner`=11, `game_over`=1.
- Win on the 9th move (X completes diagonal 0-4-8) → `winner`=01, not 11.
- `new_game` asserted together with a legal `move_valid`:
  - No ack; boards cleared; `turn`=0; PLAY next cycle.
- `reset_n` pulsed low during CHECK → outputs at reset values with no clock edge.
